costas_gear_ctrl: RTL
=====================

COSTAS_GEAR_CTRL -- requirements
Module: costas_gear_ctrl

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 4: log2 of the metric averaging window, in accepted samples; legal range 1..8.
REQ-002 SHALL have parameter LOCK_THRESH, default 128: mean |feedback| strictly below this marks a window "good".
REQ-003 SHALL have parameter LOCK_COUNT, default 8: consecutive good windows required to declare lock.
REQ-004 SHALL have parameter UNLOCK_COUNT, default 4: consecutive bad windows required to declare loss of lock.
REQ-005 SHALL have parameters ACQ_FB_SHIFT 0, ACQ_GD_SHIFT 3, TRK_FB_SHIFT 2, TRK_GD_SHIFT 5: 4-bit loop-gain shifts for acquisition and tracking.
REQ-006 SHALL have port clk_16M384, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n_16M384, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port enable, input, 1 bit: run the controller when high.
REQ-009 SHALL have port MODE_CTRL, input, 4 bits: one-hot mode (0001 BPSK, 0010 QPSK, 0100 MIX).
REQ-010 SHALL have port feedback_tdata, input, 16 bits: signed Costas loop phase-error sample.
REQ-011 SHALL have port feedback_tvalid, input, 1 bit: feedback_tdata is valid this cycle.
REQ-012 SHALL have port FEEDBACK_SHIFT, output, 4 bits, registered: Costas loop gain shift.
REQ-013 SHALL have port GARDNER_SHIFT, output, 4 bits, registered: Gardner timing-loop gain shift.
REQ-014 SHALL have port locked, output, 1 bit, registered: loop declared locked.
REQ-015 SHALL have port state, output, 2 bits, registered: IDLE=0, ACQ=1, TRACK=2, HOLD=3.
REQ-016 SHALL have port win_done, output, 1 bit, registered: one-cycle pulse per completed window decision.

Function
REQ-017 SHALL, in each cycle with feedback_tvalid=1 in ACQ, TRACK or HOLD, add |feedback_tdata| to a (16+WIN_LOG2)-bit accumulator and increment a WIN_LOG2-bit sample counter; cycles with tvalid=0 change nothing.
REQ-018 SHALL saturate |-32768| to 32767.
REQ-019 SHALL evaluate a window on the cycle its 2^WIN_LOG2-th valid sample is accepted: compute the mean (accumulator including that sample, shifted right by WIN_LOG2) and compare it with LOCK_THRESH.
REQ-020 SHALL register the decision result, state, gains, locked and win_done one cycle after that cycle, and clear the accumulator and counter in the same update so the next sample starts a new window with no sample lost.
REQ-021 SHALL transition IDLE -> ACQ on the first cycle with enable=1.
REQ-022 SHALL, in ACQ, increment good_cnt on a good window and clear it on a bad window; when good_cnt reaches LOCK_COUNT it SHALL go to TRACK and clear good_cnt.
REQ-023 SHALL, in TRACK, stay in TRACK on a good window; on a bad window it SHALL go to HOLD with bad_cnt=1.
REQ-024 SHALL, in HOLD, go to TRACK and clear bad_cnt on a good window; on a bad window it SHALL increment bad_cnt, and when bad_cnt reaches UNLOCK_COUNT it SHALL go to ACQ and clear bad_cnt.
REQ-025 SHALL output ACQ_FB_SHIFT/ACQ_GD_SHIFT in IDLE and ACQ, and TRK_FB_SHIFT/TRK_GD_SHIFT in TRACK and HOLD.
REQ-026 SHALL drive locked=1 exactly in TRACK and HOLD.
REQ-027 SHALL, when enable=0 in any state, go to IDLE on the next cycle and clear the accumulator, sample counter, good_cnt and bad_cnt; enable=0 SHALL take priority over a coincident window decision.
REQ-028 SHALL, when MODE_CTRL changes value while enabled, go to ACQ on the next cycle and clear the accumulator, counters, good_cnt and bad_cnt; this SHALL take priority over a coincident window decision.
REQ-029 SHALL treat MODE_CTRL values that are not one-hot as a mode change and stay in ACQ while the value persists, with no window decisions made.
REQ-030 SHALL size good_cnt and bad_cnt so they never wrap for the parameter values used.

Reset
REQ-031 SHALL, while rst_n_16M384=0, hold state=IDLE, locked=0, win_done=0, FEEDBACK_SHIFT=ACQ_FB_SHIFT, GARDNER_SHIFT=ACQ_GD_SHIFT, with all counters and the accumulator at 0; reset asserted mid-window SHALL discard the partial window.
REQ-032 SHALL release reset synchronously to clk_16M384 (two-stage release), so the first controller action occurs on the second rising edge after deassertion.

Verification
REQ-033 SHALL cover reset: assert rst_n_16M384=0 mid-operation -> state=0, locked=0, FEEDBACK_SHIFT=0, GARDNER_SHIFT=3, asynchronously.
REQ-034 SHALL cover lock: defaults, enable=1, tvalid=1, feedback alternating +50/-50 -> 8 win_done pulses 16 cycles apart, then state=2, locked=1, FEEDBACK_SHIFT=2, GARDNER_SHIFT=5 one cycle after the 128th sample.
REQ-035 SHALL cover the ACQ restart: 7 good windows, then one window of +200 -> state stays 1 and a further 8 good windows are needed to lock.
REQ-036 SHALL cover hysteresis: in TRACK, 3 bad windows then 1 good -> states 3,3,3,2 with locked=1 throughout; then 4 bad windows -> state=1, locked=0, gains 0/3.
REQ-037 SHALL cover saturation and gaps: -32768 samples with tvalid toggling every cycle -> a window completes after 32 cycles, mean 32767, window bad, no accumulator overflow.
REQ-038 SHALL cover mode change: in TRACK, MODE_CTRL 0010 -> 0001 coincident with a window end -> next cycle state=1, locked=0, no win_done pulse.

Source files
------------

// File: rtl/costas_gear_ctrl.sv
// costas_gear_ctrl
//   Gear-shift controller for a Costas carrier loop and a Gardner timing loop.
//   It averages |phase error| over windows of 2^WIN_LOG2 accepted samples and
//   steps an IDLE / ACQ / TRACK / HOLD state machine from the per-window
//   good/bad decision. It selects wide (acquisition) or narrow (tracking)
//   loop-gain shifts from the resulting state.
//
// Ports
//   clk_16M384       in   single clock, rising edge
//   rst_n_16M384     in   asynchronous active-low reset, released synchronously
//   enable           in   run the controller when high
//   MODE_CTRL[3:0]   in   one-hot modulation mode (0001 BPSK, 0010 QPSK, 0100 MIX)
//   feedback_tdata   in   signed 16-bit Costas phase-error sample
//   feedback_tvalid  in   feedback_tdata valid this cycle
//   FEEDBACK_SHIFT   out  Costas loop gain shift (registered)
//   GARDNER_SHIFT    out  Gardner loop gain shift (registered)
//   locked           out  high in TRACK and HOLD (registered)
//   state[1:0]       out  IDLE=0, ACQ=1, TRACK=2, HOLD=3 (registered)
//   win_done         out  one-cycle pulse per completed window decision
module costas_gear_ctrl #(
    parameter int         WIN_LOG2     = 4,
    parameter int         LOCK_THRESH  = 128,
    parameter int         LOCK_COUNT   = 8,
    parameter int         UNLOCK_COUNT = 4,
    parameter logic [3:0] ACQ_FB_SHIFT = 4'd0,
    parameter logic [3:0] ACQ_GD_SHIFT = 4'd3,
    parameter logic [3:0] TRK_FB_SHIFT = 4'd2,
    parameter logic [3:0] TRK_GD_SHIFT = 4'd5
) (
    input  logic        clk_16M384,
    input  logic        rst_n_16M384,
    input  logic        enable,
    input  logic [3:0]  MODE_CTRL,
    input  logic [15:0] feedback_tdata,
    input  logic        feedback_tvalid,
    output logic [3:0]  FEEDBACK_SHIFT,
    output logic [3:0]  GARDNER_SHIFT,
    output logic        locked,
    output logic [1:0]  state,
    output logic        win_done
);

    localparam int ACC_W = 16 + WIN_LOG2;
    localparam int GW    = $clog2(LOCK_COUNT + 1);
    localparam int BW    = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // |x| with the single unrepresentable magnitude clamped to 32767.
    function automatic logic [15:0] sat_abs(input logic signed [15:0] x);
        logic [15:0] r;
        if (x == 16'sh8000) begin
            r = 16'h7fff;
        end else if (x[15]) begin
            r = 16'(-x);
        end else begin
            r = 16'(x);
        end
        return r;
    endfunction

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [WIN_LOG2-1:0] cnt_q, cnt_d;
    logic [GW-1:0]      good_cnt_q, good_cnt_d;
    logic [BW-1:0]      bad_cnt_q, bad_cnt_d;
    logic [3:0]         mode_q, mode_d;
    logic [3:0]         fb_shift_q, fb_shift_d;
    logic [3:0]         gd_shift_q, gd_shift_d;
    logic               locked_q, locked_d;
    logic               win_done_q, win_done_d;
    logic               rel_q;

    logic [15:0]        sample_abs;
    logic [ACC_W-1:0]   sum;
    logic [ACC_W-1:0]   mean;
    logic               good;
    logic               win_end;
    logic               mode_onehot;
    logic               mode_chg;

    assign sample_abs  = sat_abs(feedback_tdata);
    assign sum         = acc_q + ACC_W'(sample_abs);
    assign mean        = sum >> WIN_LOG2;
    assign good        = (mean < ACC_W'(LOCK_THRESH));
    assign win_end     = feedback_tvalid && (cnt_q == '1);
    assign mode_onehot = (MODE_CTRL != 4'd0) && ((MODE_CTRL & (MODE_CTRL - 4'd1)) == 4'd0);
    // A non-one-hot mode counts as a change on every cycle it persists, which
    // pins the controller in ACQ with the window continually restarted.
    assign mode_chg    = (MODE_CTRL != mode_q) || !mode_onehot;

    // Reset release is retimed through rel_q; the controller register forms the
    // second stage, so the first state change lands on the second rising edge
    // after rst_n_16M384 deasserts.
    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            rel_q <= 1'b0;
        end else begin
            rel_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        mode_d     = MODE_CTRL;
        win_done_d = 1'b0;

        if (!rel_q) begin
            // still leaving reset: hold everything at its reset value
        end else if (!enable) begin
            state_d    = ST_IDLE;
            acc_d      = '0;
            cnt_d      = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (state_q == ST_IDLE || mode_chg) begin
            // Both enable-from-idle and a mode change restart acquisition from
            // a clean window and discard any decision due this cycle.
            state_d    = ST_ACQ;
            acc_d      = '0;
            cnt_d      = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else if (feedback_tvalid) begin
            acc_d = sum;
            cnt_d = cnt_q + WIN_LOG2'(1);
            if (win_end) begin
                acc_d      = '0;
                cnt_d      = '0;
                win_done_d = 1'b1;
                case (state_q)
                    ST_ACQ: begin
                        if (good) begin
                            if (good_cnt_q == GW'(LOCK_COUNT - 1)) begin
                                state_d    = ST_TRACK;
                                good_cnt_d = '0;
                            end else begin
                                good_cnt_d = good_cnt_q + GW'(1);
                            end
                        end else begin
                            good_cnt_d = '0;
                        end
                    end
                    ST_TRACK: begin
                        if (!good) begin
                            state_d   = ST_HOLD;
                            bad_cnt_d = BW'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (good) begin
                            state_d   = ST_TRACK;
                            bad_cnt_d = '0;
                        end else if (bad_cnt_q == BW'(UNLOCK_COUNT - 1)) begin
                            state_d   = ST_ACQ;
                            bad_cnt_d = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + BW'(1);
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        if (state_d == ST_TRACK || state_d == ST_HOLD) begin
            fb_shift_d = TRK_FB_SHIFT;
            gd_shift_d = TRK_GD_SHIFT;
            locked_d   = 1'b1;
        end else begin
            fb_shift_d = ACQ_FB_SHIFT;
            gd_shift_d = ACQ_GD_SHIFT;
            locked_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_16M384 or negedge rst_n_16M384) begin
        if (!rst_n_16M384) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
            mode_q     <= '0;
            fb_shift_q <= ACQ_FB_SHIFT;
            gd_shift_q <= ACQ_GD_SHIFT;
            locked_q   <= 1'b0;
            win_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
            mode_q     <= mode_d;
            fb_shift_q <= fb_shift_d;
            gd_shift_q <= gd_shift_d;
            locked_q   <= locked_d;
            win_done_q <= win_done_d;
        end
    end

    assign state          = state_q;
    assign FEEDBACK_SHIFT = fb_shift_q;
    assign GARDNER_SHIFT  = gd_shift_q;
    assign locked         = locked_q;
    assign win_done       = win_done_q;

endmodule
